operand_sel_arb: RTL and testbench

Parametrised N-channel operand selector with a registered, valid/ready output stage, for the 9-bit ALU datapath of the TPU. It generalises the 2:1 operand mux in three ways: NUM_CH input channels, WIDTH-bit data, and a run-time mode. The mode chooses between an externally selected channel and round-robin arbitration among the valid channels. It sits between the operand sources (weight/activation buffers, feedback path) and the ALU operand A/B inputs; one instance is used per operand.

---
 rtl/alu_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/operand_sel_arb.sv | 106 ++++++++++
 tb/tb_operand_sel_arb.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and widths for the 9-bit ALU datapath.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 9;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              grant_vld,
  output logic [CH_W-1:0]   grant_idx
);

  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic [CH_W-1:0]     off;
  logic [CH_W:0]       sum;

  // Rotate so ptr lands on bit 0, pick the lowest set bit, then undo the rotation.
  always_comb begin
    dbl       = {req, req} >> ptr;
    rot       = dbl[NUM_CH-1:0];
    grant_vld = 1'b0;
    off       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_vld = 1'b1;
        off       = CH_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (CH_W + 1)'(NUM_CH)) begin
      sum = sum - (CH_W + 1)'(NUM_CH);
    end
    grant_idx = sum[CH_W-1:0];
  end

endmodule

// File: rtl/operand_sel_arb.sv
// N-channel operand selector (fixed select or round-robin) feeding a registered valid/ready output stage.
module operand_sel_arb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_WIDTH,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [CH_W-1:0]         sel,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  sel_mode_e         mode_c;
  logic              load_c;
  logic              rr_vld_c;
  logic [CH_W-1:0]   rr_idx_c;
  logic              grant_vld_c;
  logic [CH_W-1:0]   grant_idx_c;
  logic              xfer_c;
  logic [WIDTH-1:0]  grant_data_c;
  logic [NUM_CH-1:0] sel_shift_c;

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [CH_W-1:0]   out_ch_q,    out_ch_d;
  logic [CH_W-1:0]   ptr_q,       ptr_d;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant_vld (rr_vld_c),
    .grant_idx (rr_idx_c)
  );

  // Grant selection and per-channel ready; an out-of-range sel grants nothing.
  always_comb begin
    mode_c      = sel_mode_e'(mode);
    load_c      = !out_valid_q || out_ready;
    sel_shift_c = in_valid >> sel;
    if (mode_c == SEL_RR) begin
      grant_vld_c = rr_vld_c;
      grant_idx_c = rr_idx_c;
    end else begin
      grant_vld_c = (32'(sel) < NUM_CH) && sel_shift_c[0];
      grant_idx_c = sel;
    end
    xfer_c       = load_c && grant_vld_c && !rst;
    in_ready     = '0;
    grant_data_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx_c == CH_W'(i)) begin
        in_ready[i]  = xfer_c;
        grant_data_c = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_c) begin
      out_valid_d = grant_vld_c;
    end
    if (xfer_c) begin
      out_data_d = grant_data_c;
      out_ch_d   = grant_idx_c;
      if (mode_c == SEL_RR) begin
        ptr_d = (grant_idx_c == CH_W'(NUM_CH - 1)) ? '0 : grant_idx_c + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_operand_sel_arb.sv
// Directed-vector bench for operand_sel_arb with WIDTH=9, NUM_CH=4.
module tb_operand_sel_arb;

  localparam int unsigned WIDTH  = 9;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic [CH_W-1:0]         sel;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_ready;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [WIDTH-1:0] ch_word [NUM_CH];

  operand_sel_arb #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input int ch);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".ch"},    32'(out_ch),    32'(ch));
    check({tag, ".data"},  32'(out_data),  32'(ch_word[ch]));
  endtask

  initial begin
    ch_word[0] = 9'h003;
    ch_word[1] = 9'h155;
    ch_word[2] = 9'h0AA;
    ch_word[3] = 9'h1FF;
    in_data   = {9'h1FF, 9'h0AA, 9'h155, 9'h003};
    rst       = 1'b1;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;

    // Reset held two cycles with every channel valid.
    settle();
    check("rst.ready0", 32'(in_ready), 32'h0);
    step();
    check("rst.ready1", 32'(in_ready), 32'h0);
    check("rst.valid1", 32'(out_valid), 32'h0);
    step();
    check("rst.ready2", 32'(in_ready), 32'h0);
    check("rst.valid2", 32'(out_valid), 32'h0);
    check("rst.data2",  32'(out_data),  32'h0);
    check("rst.ch2",    32'(out_ch),    32'h0);

    // FIXED mode, sel=2.
    rst  = 1'b0;
    mode = 1'b0;
    sel  = 2'd2;
    settle();
    check("fix.ready", 32'(in_ready), 32'b0100);
    step();
    expect_out("fix.w0", 1'b1, 2);
    for (int k = 0; k < 2; k++) begin
      check("fix.ready_hold", 32'(in_ready), 32'b0100);
      step();
      expect_out("fix.wn", 1'b1, 2);
    end

    // Round-robin from ptr 0 with wrap.
    mode = 1'b1;
    settle();
    check("rr.ready_ptr0", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      step();
      expect_out("rr.seq", 1'b1, k % 4);
    end

    // Backpressure holding ch1's word; ptr now 2.
    out_ready = 1'b0;
    settle();
    check("bp.ready", 32'(in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out("bp.hold", 1'b1, 1);
      check("bp.ready_hold", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    settle();
    check("bp.release_ready", 32'(in_ready), 32'b0100);
    step();
    expect_out("bp.next", 1'b1, 2);

    // Steer ptr to 1 via a lone ch0 request (ptr was 3, wraps to ch0).
    in_valid = 4'b0001;
    settle();
    check("sp.wrap_ready", 32'(in_ready), 32'b0001);
    step();
    expect_out("sp.ch0a", 1'b1, 0);
    in_valid = 4'b1001;
    settle();
    check("sp.ready_ch3", 32'(in_ready), 32'b1000);
    step();
    expect_out("sp.ch3", 1'b1, 3);
    check("sp.ready_ch0", 32'(in_ready), 32'b0001);
    step();
    expect_out("sp.ch0b", 1'b1, 0);

    // Switch to FIXED sel=1 (ptr is 1); then an invalid selected channel.
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'b1111;
    settle();
    check("ms.ready_sel1", 32'(in_ready), 32'b0010);
    step();
    expect_out("ms.ch1", 1'b1, 1);
    sel      = 2'd3;
    in_valid = 4'b0111;
    settle();
    check("ms.nogrant_ready", 32'(in_ready), 32'h0);
    step();
    expect_out("ms.drain", 1'b0, 1);

    // Back to RR: ptr must still be 1 after the FIXED transfer.
    mode     = 1'b1;
    in_valid = 4'b1111;
    settle();
    check("ms.ptr_kept", 32'(in_ready), 32'b0010);
    step();
    expect_out("ms.rr_ch1", 1'b1, 1);

    // Reset while the output is stalled.
    out_ready = 1'b0;
    step();
    expect_out("mr.stall", 1'b1, 1);
    rst = 1'b1;
    settle();
    check("mr.ready_in_rst", 32'(in_ready), 32'h0);
    step();
    check("mr.valid", 32'(out_valid), 32'h0);
    check("mr.data",  32'(out_data),  32'h0);
    check("mr.ch",    32'(out_ch),    32'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    settle();
    check("mr.ptr_clr", 32'(in_ready), 32'b0001);
    step();
    expect_out("mr.after", 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
